// File: rtl/exec_timer_ctrl_pkg.sv
// rtl/exec_timer_ctrl_pkg.sv - shared encodings for the processor FSM and the execution timer
//
// Purpose: processor top-FSM state encodings (shared with the display decoder),
//          the timer FSM encodings, default parameters and a width helper.
// Ports:   none (package).
package exec_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    uart_ready         = 3'd0,
    uart_receive_Imem  = 3'd1,
    uart_receive_dmem  = 3'd2,
    process_ready      = 3'd3,
    process_exicute    = 3'd4,
    uart_transmit_dmem = 3'd5,
    finish             = 3'd6
  } proc_state_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNT    = 3'd1,
    WAIT_RDY = 3'd2,
    CONVERT  = 3'd3,
    DONE     = 3'd4
  } timer_fsm_e;

  localparam int unsigned PRESCALE_DEFAULT = 50;
  localparam int unsigned TIME_W_DEFAULT   = 26;

  // Counter width for a mod-n counter; a mod-1 counter still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exec_timer_ctrl_if.sv
// rtl/exec_timer_ctrl_if.sv - handshake bundle between top FSM, timer and BCD converter
//
// Purpose: groups the processor state input, converter handshake and timer results.
// Signals: state (3b), conv_ready, conv_done            -> timer
//          timeValue (TIME_W), start_conv, time_valid, overflow <- timer
// Modports: master (FSM/converter side), slave (timer side).
interface exec_timer_if #(
  parameter int unsigned TIME_W = 26
);
  logic [2:0]        state;
  logic              conv_ready;
  logic              conv_done;
  logic [TIME_W-1:0] timeValue;
  logic              start_conv;
  logic              time_valid;
  logic              overflow;

  modport master (
    output state, conv_ready, conv_done,
    input  timeValue, start_conv, time_valid, overflow
  );

  modport slave (
    input  state, conv_ready, conv_done,
    output timeValue, start_conv, time_valid, overflow
  );
endinterface

// File: rtl/exec_timer_ctrl_prescaler.sv
// rtl/exec_timer_ctrl_prescaler.sv - mod-PRESCALE counter with registered tick
//
// Purpose: divides clk into time ticks while enabled.
// Ports:   clk_i, rst_i (sync, active-high), clr_i (zero the count),
//          en_i (advance the count), tick_o (registered: count is at PRESCALE-1,
//          i.e. the next enabled cycle wraps and is a time tick).
module tick_prescaler
  import exec_timer_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int unsigned    CW   = cnt_width(PRESCALE);
  localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // tick is registered from the next count so it is valid in the same cycle
  // the count sits at LAST; the consumer increments on the wrapping edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= (LAST == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_o = tick_q;
endmodule

// File: rtl/exec_timer_ctrl.sv
// rtl/exec_timer_ctrl.sv - execution timer and BCD-conversion sequencer
//
// Purpose: counts prescaled ticks while the processor FSM is in process_exicute,
//          freezes the count on exit, issues one start_conv to the converter and
//          flags time_valid when the converter reports done.
// Ports:   clk, rst (sync, active-high), bus (exec_timer_if.slave):
//          state, conv_ready, conv_done in; timeValue, start_conv, time_valid, overflow out.
// Config:  TIMER_SATURATE_EN - timeValue saturates at all-ones and sets sticky
//          overflow; otherwise timeValue wraps and overflow is tied low.
module exec_timer_ctrl
  import exec_timer_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
  parameter int unsigned TIME_W   = TIME_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  exec_timer_if.slave  bus
);
  timer_fsm_e        fsm_q, fsm_d;
  logic [2:0]        prev_state_q;
  logic [TIME_W-1:0] time_q, time_d;
  logic              time_valid_q, time_valid_d;
  logic              start_conv;
  logic              in_exec, restart, count_en, tick;
`ifdef TIMER_SATURATE_EN
  logic              overflow_q, overflow_d;
`endif

  assign in_exec  = (bus.state == process_exicute);
  // Entry edge into process_exicute; beats every other transition.
  assign restart  = in_exec && (prev_state_q != process_exicute);
  assign count_en = (fsm_q == COUNT) && in_exec && !restart;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (restart),
    .en_i   (count_en),
    .tick_o (tick)
  );

  always_comb begin
    fsm_d        = fsm_q;
    time_d       = time_q;
    time_valid_d = time_valid_q;
    start_conv   = 1'b0;
`ifdef TIMER_SATURATE_EN
    overflow_d   = overflow_q;
`endif
    if (restart) begin
      fsm_d        = COUNT;
      time_d       = '0;
      time_valid_d = 1'b0;
`ifdef TIMER_SATURATE_EN
      overflow_d   = 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
        end
        COUNT: begin
          // Leaving process_exicute freezes time in that very cycle.
          if (!in_exec) begin
            fsm_d = WAIT_RDY;
          end else if (tick) begin
`ifdef TIMER_SATURATE_EN
            if (&time_q) begin
              overflow_d = 1'b1;
            end else begin
              time_d = time_q + TIME_W'(1);
            end
`else
            time_d = time_q + TIME_W'(1);
`endif
          end
        end
        WAIT_RDY: begin
          // Mealy pulse so a coincident restart can suppress it.
          if (bus.conv_ready) begin
            start_conv = 1'b1;
            fsm_d      = CONVERT;
          end
        end
        CONVERT: begin
          if (bus.conv_done) begin
            time_valid_d = 1'b1;
            fsm_d        = DONE;
          end
        end
        DONE: begin
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      prev_state_q <= uart_ready;
      time_q       <= '0;
      time_valid_q <= 1'b0;
`ifdef TIMER_SATURATE_EN
      overflow_q   <= 1'b0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= bus.state;
      time_q       <= time_d;
      time_valid_q <= time_valid_d;
`ifdef TIMER_SATURATE_EN
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign bus.timeValue  = time_q;
  assign bus.start_conv = start_conv;
  assign bus.time_valid = time_valid_q;
`ifdef TIMER_SATURATE_EN
  assign bus.overflow   = overflow_q;
`else
  assign bus.overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_exec_timer_ctrl.sv
// tb/tb_exec_timer_ctrl.sv - self-checking bench for exec_timer_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_exec_timer_ctrl;
  import exec_timer_ctrl_pkg::*;

  localparam int P_A = 4;
  localparam int W_A = 26;
  localparam int P_B = 1;
  localparam int W_B = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st;
  logic       rdy, done;

  always #5 clk = ~clk;

  exec_timer_if #(.TIME_W(W_A)) bus_a ();
  exec_timer_if #(.TIME_W(W_B)) bus_b ();

  assign bus_a.state      = st;
  assign bus_a.conv_ready = rdy;
  assign bus_a.conv_done  = done;
  assign bus_b.state      = st;
  assign bus_b.conv_ready = rdy;
  assign bus_b.conv_done  = done;

  exec_timer_ctrl #(.PRESCALE(P_A), .TIME_W(W_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  exec_timer_ctrl #(.PRESCALE(P_B), .TIME_W(W_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: elapsed = cycles spent counting after the entry cycle;
  // time = elapsed / PRESCALE. Phase flags track the conversion handshake.
  int elapsed = 0;
  bit counting = 0, pending = 0, waiting = 0, valid = 0, prev_exec = 0, started = 0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      elapsed <= 0; counting <= 0; pending <= 0; waiting <= 0; valid <= 0; prev_exec <= 0;
    end else begin
      if (st == 3'd4 && !prev_exec) begin
        elapsed <= 0; counting <= 1; pending <= 0; waiting <= 0; valid <= 0;
      end else if (counting) begin
        if (st == 3'd4) elapsed <= elapsed + 1;
        else begin counting <= 0; pending <= 1; end
      end else if (pending) begin
        if (rdy) begin pending <= 0; waiting <= 1; end
      end else if (waiting) begin
        if (done) begin waiting <= 0; valid <= 1; end
      end
      prev_exec <= (st == 3'd4);
    end
  end

  function automatic longint exp_time(input int p, input int w);
    longint t    = longint'(elapsed / p);
    longint maxv = (longint'(1) << w) - 1;
`ifdef TIMER_SATURATE_EN
    return (t > maxv) ? maxv : t;
`else
    return t & maxv;
`endif
  endfunction

  function automatic bit exp_ovf(input int p, input int w);
`ifdef TIMER_SATURATE_EN
    return longint'(elapsed / p) > ((longint'(1) << w) - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_start();
    return pending && rdy && !(st == 3'd4 && !prev_exec);
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("a.timeValue",  bus_a.timeValue,  exp_time(P_A, W_A));
      check("a.start_conv", bus_a.start_conv, exp_start());
      check("a.time_valid", bus_a.time_valid, valid);
      check("a.overflow",   bus_a.overflow,   exp_ovf(P_A, W_A));
      check("b.timeValue",  bus_b.timeValue,  exp_time(P_B, W_B));
      check("b.start_conv", bus_b.start_conv, exp_start());
      check("b.time_valid", bus_b.time_valid, valid);
      check("b.overflow",   bus_b.overflow,   exp_ovf(P_B, W_B));
    end
  end

  int n_start = 0;
  always @(negedge clk) if (bus_a.start_conv === 1'b1) n_start <= n_start + 1;

  task automatic step(input logic [2:0] s, input logic r, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      st = s; rdy = r; done = d;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int s0;
    logic [2:0] rs;
    st = 3'd0; rdy = 1'b0; done = 1'b0; rst = 1'b1;
    step(3'd0, 0, 0, 2);
    rst = 1'b0;

    // 1: reset mid-COUNT
    step(3'd4, 0, 0, 6);
    rst = 1'b1;
    step(3'd4, 0, 0, 1);
    rst = 1'b0;
    check("t1.timeValue", bus_a.timeValue, 0);
    check("t1.time_valid", bus_a.time_valid, 0);
    check("t1.overflow", bus_a.overflow, 0);
    s0 = n_start;
    step(3'd0, 1, 0, 3);
    check("t1.idle_no_start", n_start - s0, 0);

    // 2: entry + 40 counting cycles, exit with conv_ready high
    step(3'd4, 0, 0, 41);
    s0 = n_start;
    step(3'd6, 1, 0, 1);
    step(3'd6, 1, 0, 4);
    check("t2.start_pulses", n_start - s0, 1);
    check("t2.timeValue", bus_a.timeValue, 10);
    step(3'd6, 0, 0, 29);
    check("t2.valid_before_done", bus_a.time_valid, 0);
    step(3'd6, 0, 1, 1);
    check("t2.valid_after_done", bus_a.time_valid, 1);
    step(3'd6, 0, 0, 3);
    check("t2.timeValue_held", bus_a.timeValue, 10);

    // 3: conv_ready held low, then raised
    step(3'd4, 0, 0, 9);
    s0 = n_start;
    step(3'd6, 0, 0, 20);
    check("t3.no_start_while_busy", n_start - s0, 0);
    step(3'd6, 1, 0, 3);
    check("t3.single_start", n_start - s0, 1);
    check("t3.timeValue", bus_a.timeValue, 2);

    // 4: restart during CONVERT, stale conv_done ignored
    step(3'd4, 0, 0, 3);
    step(3'd4, 0, 1, 1);
    step(3'd4, 0, 0, 5);
    check("t4.timeValue", bus_a.timeValue, 2);
    check("t4.valid_ignored", bus_a.time_valid, 0);
    step(3'd6, 0, 0, 2);
    check("t4.valid_still_0", bus_a.time_valid, 0);

    // 5: 20 counting cycles on the narrow, undivided instance
    rst = 1'b1;
    step(3'd0, 0, 0, 1);
    rst = 1'b0;
    step(3'd4, 0, 0, 21);
    step(3'd6, 0, 0, 2);
`ifdef TIMER_SATURATE_EN
    check("t5.b.timeValue", bus_b.timeValue, 15);
    check("t5.b.overflow", bus_b.overflow, 1);
`else
    check("t5.b.timeValue", bus_b.timeValue, 4);
    check("t5.b.overflow", bus_b.overflow, 0);
`endif
    check("t5.a.timeValue", bus_a.timeValue, 5);

    // 6: exec -> finish -> exec on consecutive cycles with conv_ready high
    s0 = n_start;
    step(3'd4, 1, 0, 1);
    step(3'd6, 1, 0, 1);
    step(3'd4, 1, 0, 1);
    check("t6.no_start", n_start - s0, 0);
    check("t6.timeValue_restart", bus_a.timeValue, 0);
    step(3'd4, 1, 0, 4);
    check("t6.first_tick", bus_a.timeValue, 1);

    // Randomised traffic against the model
    rs = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        rs = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 6)) : 3'd4;
      rst = ($urandom_range(0, 599) == 0);
      step(rs, $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0, 1);
    end
    rst = 1'b0;
    step(3'd0, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
